// File: rtl/music_note_decoder.sv
// Square-wave tone decoder: measures the rising-to-rising period of audio_in in clk cycles
// and maps it to the player's 12-bit {high,med,low} note code.
// Optional build macro NOTE_DEC_DEGLITCH_EN adds a 4-cycle level filter after the synchronizer.
// PERIOD_SHIFT scales the nominal note periods down by 2^PERIOD_SHIFT (0 = real 50 MHz table).
module music_note_decoder #(
  parameter int unsigned MATCH_CNT    = 2,
  parameter int unsigned TIMEOUT_CYC  = 200000,
  parameter int unsigned CNT_W        = 18,
  parameter int unsigned PERIOD_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             audio_in,
  output logic [11:0]      note_code,
  output logic             note_valid,
  output logic             silence,
  output logic [CNT_W-1:0] period,
  output logic             bad_period
);

  localparam int unsigned NumNotes = 21;
  localparam int unsigned NomPeriod [NumNotes] = '{
    183216, 163280, 145472, 137552, 122464, 109104, 97184,
    91792,  81792,  72848,  68784,  61248,  54560,  48592,
    45904,  40864,  36432,  34368,  30624,  27296,  24416
  };
  localparam logic [11:0] NoteCode [NumNotes] = '{
    12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007,
    12'h010, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060, 12'h070,
    12'h100, 12'h200, 12'h300, 12'h400, 12'h500, 12'h600, 12'h700
  };
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);
  localparam logic [2:0]       MatchMax   = 3'(MATCH_CNT);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StClassify} state_e;

  state_e           state_q;
  logic             sync1_q, sync2_q;
  logic             lvl, lvl_prev_q, rise;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [2:0]       match_q, match_nxt;
  logic [11:0]      last_code_q;
  logic             upd_q;
  logic [11:0]      upd_code_q;
  logic [31:0]      per_ext;
  logic             cls_hit;
  logic [11:0]      cls_code;

  // Two-flop synchronizer for the asynchronous audio line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= audio_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef NOTE_DEC_DEGLITCH_EN
  logic       filt_q;
  logic [1:0] stab_q;

  // Accept a new level only after it has been seen for 4 consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= 2'd0;
    end else if (sync2_q == filt_q) begin
      stab_q <= 2'd0;
    end else if (stab_q == 2'd3) begin
      filt_q <= sync2_q;
      stab_q <= 2'd0;
    end else begin
      stab_q <= stab_q + 2'd1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  // Previous level for the rising-edge strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_prev_q <= 1'b0;
    else        lvl_prev_q <= lvl;
  end

  assign rise    = lvl & ~lvl_prev_q;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign per_ext = 32'(period);

  // Window lookup: Pn +/- Pn/64 inclusive; windows are disjoint so at most one hits
  always_comb begin
    cls_hit  = 1'b0;
    cls_code = 12'h000;
    for (int unsigned i = 0; i < NumNotes; i++) begin
      if (per_ext >= (NomPeriod[i] >> PERIOD_SHIFT) - (NomPeriod[i] >> (PERIOD_SHIFT + 6)) &&
          per_ext <= (NomPeriod[i] >> PERIOD_SHIFT) + (NomPeriod[i] >> (PERIOD_SHIFT + 6))) begin
        cls_hit  = 1'b1;
        cls_code = NoteCode[i];
      end
    end
  end

  // Consecutive-match count for the current classification (0 = no usable history)
  always_comb begin
    match_nxt = 3'd1;
    if (!cls_hit) begin
      match_nxt = 3'd0;
    end else if (match_q != 3'd0 && cls_code == last_code_q) begin
      match_nxt = (match_q >= MatchMax) ? MatchMax : match_q + 3'd1;
    end
  end

  // Measurement FSM with registered outputs; note updates land one cycle after CLASSIFY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      match_q     <= 3'd0;
      last_code_q <= 12'h000;
      upd_q       <= 1'b0;
      upd_code_q  <= 12'h000;
      note_code   <= 12'h000;
      note_valid  <= 1'b0;
      silence     <= 1'b1;
      period      <= '0;
      bad_period  <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      bad_period <= 1'b0;
      upd_q      <= 1'b0;
      if (!enable) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        match_q     <= 3'd0;
        last_code_q <= 12'h000;
        period      <= '0;
        note_code   <= 12'h000;
        silence     <= 1'b1;
        note_valid  <= (note_code != 12'h000);
      end else begin
        if (upd_q) begin
          note_code  <= upd_code_q;
          silence    <= 1'b0;
          note_valid <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            state_q <= StArm;
            cnt_q   <= '0;
          end
          StArm, StMeasure: begin
            if (rise) begin
              // First edge only opens a measurement; later edges close one
              if (state_q == StMeasure) begin
                period  <= cnt_q;
                state_q <= StClassify;
              end else begin
                state_q <= StMeasure;
              end
              cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt_q >= TimeoutVal) begin
              state_q    <= StArm;
              cnt_q      <= '0;
              match_q    <= 3'd0;
              note_code  <= 12'h000;
              silence    <= 1'b1;
              note_valid <= (note_code != 12'h000);
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StClassify: begin
            state_q <= StMeasure;
            cnt_q   <= cnt_inc;
            match_q <= match_nxt;
            if (!cls_hit) begin
              bad_period <= 1'b1;
            end else begin
              last_code_q <= cls_code;
              if (match_nxt == MatchMax && cls_code != note_code) begin
                upd_q      <= 1'b1;
                upd_code_q <= cls_code;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_note_decoder.sv
// Scoreboard bench for music_note_decoder with a scaled note table (PERIOD_SHIFT=6).
module tb_music_note_decoder;
  localparam int MatchCnt   = 2;
  localparam int TimeoutCyc = 3000;
  localparam int CntW       = 18;
  localparam int Shift      = 6;

  logic            clk = 1'b0, rst_n = 1'b0, enable = 1'b0, audio_in = 1'b0;
  logic [11:0]     note_code;
  logic            note_valid, silence, bad_period;
  logic [CntW-1:0] period;

  music_note_decoder #(
    .MATCH_CNT   (MatchCnt),
    .TIMEOUT_CYC (TimeoutCyc),
    .CNT_W       (CntW),
    .PERIOD_SHIFT(Shift)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .audio_in  (audio_in),
    .note_code (note_code),
    .note_valid(note_valid),
    .silence   (silence),
    .period    (period),
    .bad_period(bad_period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad_cnt = 0;

  typedef struct {
    bit          is_bad;
    logic [11:0] code;
    int          lo;
    int          hi;
  } ev_t;
  ev_t exp_q[$];

  // Nominal full-rate periods in note order L1..L7, M1..M7, H1..H7
  int full_nom [21] = '{183216, 163280, 145472, 137552, 122464, 109104, 97184,
                        91792, 81792, 72848, 68784, 61248, 54560, 48592,
                        45904, 40864, 36432, 34368, 30624, 27296, 24416};

  // Reference model state
  logic [11:0] m_note = 12'h000, m_prev = 12'h000;
  int          m_match = 0, m_start = 0;
  bit          m_meas = 1'b0;

  function automatic int nom(input int i);
    return full_nom[i] >> Shift;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input bit is_bad, input logic [11:0] code, input int lo, input int hi);
    ev_t e;
    e.is_bad = is_bad;
    e.code   = code;
    e.lo     = lo;
    e.hi     = hi;
    exp_q.push_back(e);
  endtask

  // Note index i -> degree (i%7)+1 in nibble i/7
  task automatic classify(input int p, output bit hit, output logic [11:0] code);
    hit  = 1'b0;
    code = 12'h000;
    for (int i = 0; i < 21; i++) begin
      int n;
      n = nom(i);
      if (p >= n - n / 64 && p <= n + n / 64) begin
        hit  = 1'b1;
        code = 12'((i % 7 + 1) << (4 * (i / 7)));
      end
    end
  endtask

  task automatic model_edge();
    bit          hit;
    logic [11:0] code;
    int          p;
    if (!m_meas) begin
      m_meas  = 1'b1;
      m_start = cyc;
    end else begin
      p       = cyc - m_start;
      m_start = cyc;
      classify(p, hit, code);
      if (!hit) begin
        m_match = 0;
        push_ev(1'b1, m_note, cyc + 1, cyc + 12);
      end else begin
        if (m_match > 0 && code == m_prev) m_match = (m_match < MatchCnt) ? m_match + 1 : MatchCnt;
        else m_match = 1;
        m_prev = code;
        if (m_match == MatchCnt && code != m_note) begin
          m_note = code;
          push_ev(1'b0, code, cyc + 1, cyc + 12);
        end
      end
    end
  endtask

  task automatic model_timeout();
    if (m_note != 12'h000) push_ev(1'b0, 12'h000, m_start + TimeoutCyc, m_start + TimeoutCyc + 12);
    m_note  = 12'h000;
    m_match = 0;
    m_meas  = 1'b0;
  endtask

  task automatic model_disable();
    if (m_note != 12'h000) push_ev(1'b0, 12'h000, cyc, cyc + 4);
    m_note  = 12'h000;
    m_match = 0;
    m_meas  = 1'b0;
  endtask

  task automatic hi(input int n);
    audio_in = 1'b1;
    model_edge();
    repeat (n) @(negedge clk);
  endtask

  task automatic lo(input int n);
    audio_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic tone(input int p, input int n);
    repeat (n) begin
      hi(p / 2);
      lo(p - p / 2);
    end
  endtask

  // Monitor: pop an expectation for every pulse; flag expectations that go stale
  ev_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (note_valid && bad_period) check("both_pulse", 32'(note_valid & bad_period), 32'd0);
        if (note_valid || bad_period) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({note_valid, bad_period}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ev_kind", 32'(bad_period), 32'(e.is_bad));
            check("ev_code", 32'(note_code), 32'(e.code));
            if (!e.is_bad) check("ev_silence", 32'(silence), 32'(e.code == 12'h000));
            total++;
            if (cyc < e.lo || cyc > e.hi) begin
              bad_cnt++;
              $display("FAIL ev_time: got cycle %0d want %0d..%0d", cyc, e.lo, e.hi);
            end
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
          total++;
          bad_cnt++;
          $display("FAIL ev_missing: got no pulse by cycle %0d want bad=%0d code=%h", cyc,
                   exp_q[0].is_bad, exp_q[0].code);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int m1, m5, bw, p, k;
    m1 = nom(7);
    m5 = nom(11);
    bw = 100000 >> Shift;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(note_code), 32'h000);
    check("rst_silence", 32'(silence), 32'd1);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_bad", 32'(bad_period), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    lo(20);

    // Acquire M1, then reset asynchronously in the middle of a measurement
    tone(m1, 3);
    check("pre_arst_code", 32'(note_code), 32'h010);
    hi(300);
    #3;
    rst_n    = 1'b0;
    audio_in = 1'b0;
    #1;
    check("arst_code", 32'(note_code), 32'h000);
    check("arst_silence", 32'(silence), 32'd1);
    check("arst_valid", 32'(note_valid), 32'd0);
    check("arst_period", 32'(period), 32'd0);
    check("arst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_note  = 12'h000;
    m_match = 0;
    m_meas  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lo(20);

    // M1 acquisition
    tone(m1, 3);
    check("m1_code", 32'(note_code), 32'h010);
    check("m1_silence", 32'(silence), 32'd0);
    check("m1_period", 32'(period), 32'(m1));

    // Between-window period, then the M1 window edges
    tone(bw, 3);
    check("bw_code", 32'(note_code), 32'h010);
    tone(m1 - m1 / 64 - 1, 1);
    tone(m1 - m1 / 64, 1);
    tone(m1 + m1 / 64, 1);
    tone(m1 + m1 / 64 + 1, 1);
    tone(m1, 2);
    check("edge_code", 32'(note_code), 32'h010);

    // Switch to M5
    tone(m5, 3);
    check("m5_code", 32'(note_code), 32'h050);
    check("m5_period", 32'(period), 32'(m5));

    // Silence timeout
    model_timeout();
    lo(TimeoutCyc + 40);
    check("to_code", 32'(note_code), 32'h000);
    check("to_silence", 32'(silence), 32'd1);

    // Short glitch in the low phase of an M1 tone
    tone(m1, 3);
    repeat (2) begin
      hi(m1 / 2);
      lo(358);
      audio_in = 1'b1;
`ifndef NOTE_DEC_DEGLITCH_EN
      model_edge();
`endif
      repeat (2) @(negedge clk);
      lo(m1 - m1 / 2 - 360);
    end
    tone(m1, 3);
    check("glitch_code", 32'(note_code), 32'h010);

    // Random in-window and arbitrary periods
    for (int it = 0; it < 15; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(380, 2000);
      end else begin
        k = $urandom_range(7, 20);
        p = nom(k) - nom(k) / 64 + $urandom_range(0, 2 * (nom(k) / 64));
      end
      tone(p, $urandom_range(1, 2));
      check("rnd_code", 32'(note_code), 32'(m_note));
    end

    // Close the last period, then disable
    hi(300);
    repeat (20) @(negedge clk);
    model_disable();
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("dis_code", 32'(note_code), 32'h000);
    check("dis_silence", 32'(silence), 32'd1);
    check("dis_period", 32'(period), 32'd0);
    check("q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
